// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO read-side packer.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_PACK_RATIO = 4;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    FULL,
    FLUSH
  } pk_state_e;

  // Contiguous mask of n ones from bit 0; callers truncate to their lane count.
  function automatic logic [31:0] keep_mask(input int unsigned n);
    keep_mask = (n >= 32) ? '1 : ((32'd1 << n) - 32'd1);
  endfunction

endpackage

// File: rtl/fifo_rd_timeout.sv
// Idle counter: clear restarts it, counts while enabled, expire pulses as it reaches TIMEOUT.
// Latency: expire is combinational on the cycle the count would hit TIMEOUT; no backpressure.
module fifo_rd_timeout #(
  parameter int TIMEOUT = 16
) (
  input  logic rd_clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  generate
    if (TIMEOUT == 0) begin : g_off
      logic unused_to;
      assign unused_to = ^{rd_clk, rst_n, clr, en};
      assign expire    = 1'b0;
    end else begin : g_on
      localparam int W = $clog2(TIMEOUT + 1);
      logic [W-1:0] cnt;

      always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt <= '0;
        end else if (clr) begin
          cnt <= '0;
        end else if (en && cnt != W'(TIMEOUT)) begin
          cnt <= cnt + W'(1);
        end
      end

      assign expire = en && !clr && (cnt == W'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/fifo_rd_packer.sv
// Packs PACK_RATIO FIFO words into one keep-masked word; FIFO_RD_PACKER_STATS_EN adds counters.
// Latency: out_valid one cycle after the last lane lands; pops stop once out slot and accumulator are full.
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PACK_RATIO = DEF_PACK_RATIO,
  parameter int TIMEOUT    = 16
) (
  input  logic                             rd_clk,
  input  logic                             rst_n,
  input  logic                             fifo_empty,
  output logic                             fifo_rd,
  input  logic                             fifo_valid,
  input  logic [DATA_WIDTH-1:0]            fifo_rdata,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] out_data,
  output logic [PACK_RATIO-1:0]            out_keep,
  output logic                             out_valid,
  input  logic                             out_ready,
  input  logic                             flush_req,
  output logic                             err_unexpected,
  output logic [31:0]                      word_count,
  output logic [15:0]                      flush_count
);

  localparam int CW = $clog2(PACK_RATIO + 1);
  localparam logic [CW-1:0] LAST  = CW'(PACK_RATIO - 1);
  localparam logic [CW-1:0] FULLN = CW'(PACK_RATIO);

  pk_state_e                             state;
  logic [PACK_RATIO-1:0][DATA_WIDTH-1:0] acc, acc_nxt, flush_word;
  logic [CW-1:0]                         acc_cnt;
  logic [CW:0]                           occ;
  logic inflight, capture, slot_free, launch, flushing, expire, to_clr, to_en;

  assign capture   = fifo_valid && inflight;
  assign slot_free = !out_valid || out_ready;
  assign flushing  = (state == FLUSH);
  assign launch    = capture && (acc_cnt == LAST) && slot_free && !flushing;
  assign occ       = {1'b0, acc_cnt} + (CW+1)'(inflight);
  assign fifo_rd   = !fifo_empty && !flushing && ((occ < (CW+1)'(PACK_RATIO)) || launch);

  // acc_nxt is the accumulator with the arriving word dropped into its lane.
  always_comb begin
    acc_nxt    = acc;
    flush_word = '0;
    for (int i = 0; i < PACK_RATIO; i++) begin
      if (acc_cnt == CW'(i)) acc_nxt[i] = fifo_rdata;
      if (CW'(i) < acc_cnt) flush_word[i] = acc[i];
    end
  end

  assign to_en  = (state == FILL);
  assign to_clr = capture || (state != FILL);

  fifo_rd_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .rd_clk (rd_clk),
    .rst_n  (rst_n),
    .clr    (to_clr),
    .en     (to_en),
    .expire (expire)
  );

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      acc            <= '0;
      acc_cnt        <= '0;
      inflight       <= 1'b0;
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_keep       <= '0;
      err_unexpected <= 1'b0;
    end else begin
      inflight <= fifo_rd;
      if (fifo_valid && !inflight) err_unexpected <= 1'b1;
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (capture) acc <= acc_nxt;

      case (state)
        IDLE, FILL: begin
          if (launch) begin
            out_data  <= acc_nxt;
            out_keep  <= '1;
            out_valid <= 1'b1;
            acc_cnt   <= '0;
            state     <= IDLE;
          end else if (capture && acc_cnt == LAST) begin
            acc_cnt <= FULLN;
            state   <= FULL;
          end else begin
            if (capture) begin
              acc_cnt <= acc_cnt + CW'(1);
              state   <= FILL;
            end
            if (expire || (flush_req && (state == FILL || inflight))) state <= FLUSH;
          end
        end
        FULL: begin
          if (slot_free) begin
            out_data  <= acc;
            out_keep  <= '1;
            out_valid <= 1'b1;
            acc_cnt   <= '0;
            state     <= IDLE;
          end
        end
        FLUSH: begin
          // Absorb the last in-flight word before the partial word goes out.
          if (capture) begin
            acc_cnt <= acc_cnt + CW'(1);
          end else if (!inflight && slot_free) begin
            out_data  <= flush_word;
            out_keep  <= PACK_RATIO'(keep_mask(32'(acc_cnt)));
            out_valid <= (acc_cnt != '0);
            acc_cnt   <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_RD_PACKER_STATS_EN
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      word_count  <= '0;
      flush_count <= '0;
    end else if (out_valid && out_ready) begin
      word_count <= word_count + 32'd1;
      if (out_keep != '1 && flush_count != 16'hFFFF) flush_count <= flush_count + 16'd1;
    end
  end
`else
  assign word_count  = '0;
  assign flush_count = '0;
`endif

endmodule
